// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO controller: LED register, buffered UART transmitter and a polling status word.
// Define IO_TIMER_EN to add a loadable 32-bit free-running timer at word-select bit 3.
module io_bus_ctrl #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 3,
  parameter int LED_BITS    = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         IO_mem_addr,
  input  logic [31:0]         IO_mem_wdata,
  input  logic                IO_mem_wr,
  output logic [31:0]         IO_mem_rdata,
  output logic [LED_BITS-1:0] LEDS,
  output logic                uart_tx
);

  localparam int DIV_RAW = CLK_FREQ_HZ / BAUD;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic sel_led, sel_data, sel_stat, sel_tmr;
  logic unused_bits;

  assign sel_led  = IO_mem_addr[2];
  assign sel_data = IO_mem_addr[3];
  assign sel_stat = IO_mem_addr[4];
  assign sel_tmr  = IO_mem_addr[5];
  assign unused_bits = ^{IO_mem_addr[31:6], IO_mem_addr[1:0], IO_mem_wdata[31:8], sel_tmr};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      LEDS <= '0;
    end else if (IO_mem_wr && sel_led) begin
      LEDS <= IO_mem_wdata[LED_BITS-1:0];
    end
  end

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push_req, push, pop;
  logic               overflow;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = IO_mem_wr & sel_data;
  assign push     = push_req & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= IO_mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh overflow takes priority over a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (push_req && full) begin
      overflow <= 1'b1;
    end else if (IO_mem_wr && sel_stat) begin
      overflow <= 1'b0;
    end
  end

  tx_state_t      state, state_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [7:0]     shreg, shreg_n;
  logic           tx_bit;
  logic           busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      baud_cnt <= baud_n;
      shreg    <= shreg_n;
      uart_tx  <= tx_bit;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    baud_n    = baud_cnt;
    shreg_n   = shreg;
    pop       = 1'b0;
    tx_bit    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          baud_n  = DIV_M1;
          state_n = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (baud_cnt == '0) begin
          baud_n    = DIV_M1;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        tx_bit = shreg[0];
        if (baud_cnt == '0) begin
          baud_n    = DIV_M1;
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          baud_n  = DIV_M1;
          state_n = IDLE;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = !empty || (state != IDLE);

`ifdef IO_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= '0;
    end else if (IO_mem_wr && sel_tmr) begin
      timer <= IO_mem_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  logic [31:0] status;

  // Overlapping selects OR their sources together; nothing selected reads as zero.
  always_comb begin
    status              = '0;
    status[FIFO_AW:0]   = count;
    status[8]           = full;
    status[9]           = busy;
    status[10]          = overflow;
    IO_mem_rdata        = '0;
    if (sel_led)  IO_mem_rdata = IO_mem_rdata | 32'(LEDS);
    if (sel_stat) IO_mem_rdata = IO_mem_rdata | status;
`ifdef IO_TIMER_EN
    if (sel_tmr)  IO_mem_rdata = IO_mem_rdata | timer;
`endif
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl at DIV=10: register vector table, UART scoreboard
// fed by a serial receiver, and hand-written reset/overflow/timer sequences.
module tb_io_bus_ctrl;

  localparam int DIV = 10;
  localparam logic [31:0] A_LED  = 32'h0040_0004;
  localparam logic [31:0] A_DATA = 32'h0040_0008;
  localparam logic [31:0] A_STAT = 32'h0040_0010;
  localparam logic [31:0] A_TMR  = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] IO_mem_addr = '0;
  logic [31:0] IO_mem_wdata = '0;
  logic        IO_mem_wr = 1'b0;
  logic [31:0] IO_mem_rdata;
  logic [5:0]  LEDS;
  logic        uart_tx;

  io_bus_ctrl #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .FIFO_AW(3),
    .LED_BITS(6)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .IO_mem_addr(IO_mem_addr),
    .IO_mem_wdata(IO_mem_wdata),
    .IO_mem_wr(IO_mem_wr),
    .IO_mem_rdata(IO_mem_rdata),
    .LEDS(LEDS),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic       rx_busy = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_leds;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
    IO_mem_addr  = a;
    IO_mem_wdata = d;
    IO_mem_wr    = w;
    tick();
    IO_mem_wr = 1'b0;
    #1;
  endtask

  task automatic read_at(input logic [31:0] a, output logic [31:0] data);
    IO_mem_addr = a;
    #1;
    data = IO_mem_rdata;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_busy) && n < budget) begin
      tick();
      n++;
    end
    check_output(name, exp_q.size(), 32'd0);
  endtask

  // Serial receiver: samples mid-bit and scores each frame against the queue.
  logic [7:0] rx_byte;
  logic       rx_start, rx_stop;
  always begin
    @(posedge clk);
    #1;
    if (mon_en && uart_tx === 1'b0) begin
      rx_busy = 1'b1;
      starts.push_back(cyc);
      repeat (DIV / 2) tick();
      rx_start = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) tick();
        rx_byte[i] = uart_tx;
      end
      repeat (DIV) tick();
      rx_stop = uart_tx;
      if (exp_q.size() == 0) begin
        check_output("uart_unexpected_frame", {22'd0, rx_stop, rx_byte, rx_start}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check_output("uart_frame", {22'd0, rx_stop, rx_byte, rx_start}, {22'd0, 1'b1, e, 1'b0});
      end
      rx_busy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  d55;
    int          wr_cyc;
    int          lows;
    int          wave_err;
    logic        exp_tx;

    vecs[0]  = '{A_LED,         32'h0000_002A, 1'b1, 32'h0000_002A, 6'h2A, "led_wr"};
    vecs[1]  = '{A_LED,         32'h0000_0000, 1'b0, 32'h0000_002A, 6'h2A, "led_rd"};
    vecs[2]  = '{A_LED,         32'hFFFF_FFC5, 1'b1, 32'h0000_0005, 6'h05, "led_trunc"};
    vecs[3]  = '{A_DATA,        32'h0000_0000, 1'b0, 32'h0000_0000, 6'h05, "data_rd"};
    vecs[4]  = '{A_STAT,        32'h0000_0000, 1'b0, 32'h0000_0000, 6'h05, "stat_rd"};
    vecs[5]  = '{32'h0040_0014, 32'h0000_0000, 1'b0, 32'h0000_0005, 6'h05, "led_stat_or"};
    vecs[6]  = '{32'h0040_0040, 32'h0000_0000, 1'b0, 32'h0000_0000, 6'h05, "unmapped_rd"};
    vecs[7]  = '{32'h0040_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 6'h05, "nosel_rd"};
    vecs[8]  = '{32'h0040_0040, 32'h0000_003F, 1'b1, 32'h0000_0000, 6'h05, "unmapped_wr"};
    vecs[9]  = '{32'h0040_000C, 32'h0000_0000, 1'b0, 32'h0000_0005, 6'h05, "led_data_or"};
    vecs[10] = '{32'h0040_0024, 32'h0000_0011, 1'b1, 32'h0000_0011, 6'h11, "led_tmr_wr"};
    vecs[11] = '{A_STAT,        32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 6'h11, "stat_wr"};

    // Reset, then abort a frame in progress with queued bytes behind it.
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_output("reset_leds", 32'(LEDS), 32'h0);
    check_output("reset_tx", 32'(uart_tx), 32'h1);
    apply_stimulus(A_LED, 32'h3F, 1'b1);
    apply_stimulus(A_DATA, 32'hA5, 1'b1);
    apply_stimulus(A_DATA, 32'h11, 1'b1);
    apply_stimulus(A_DATA, 32'h22, 1'b1);
    repeat (40) tick();
    check_output("pre_reset_leds", 32'(LEDS), 32'h3F);
    resetn = 1'b0;
    tick();
    check_output("midframe_reset_leds", 32'(LEDS), 32'h0);
    check_output("midframe_reset_tx", 32'(uart_tx), 32'h1);
    read_at(A_STAT, rd);
    check_output("midframe_reset_status", rd, 32'h0);
    resetn = 1'b1;
    lows = 0;
    repeat (150) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check_output("queue_discarded", lows, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
      check_output({vecs[i].name, "_rdata"}, IO_mem_rdata, vecs[i].exp_rdata);
      check_output({vecs[i].name, "_leds"}, 32'(LEDS), 32'(vecs[i].exp_leds));
    end

`ifdef IO_TIMER_EN
    apply_stimulus(A_TMR, 32'hFFFF_FFFE, 1'b1);
    check_output("tmr_load", IO_mem_rdata, 32'hFFFF_FFFE);
    tick();
    check_output("tmr_inc", IO_mem_rdata, 32'hFFFF_FFFF);
    tick();
    check_output("tmr_wrap", IO_mem_rdata, 32'h0000_0000);
`else
    apply_stimulus(A_TMR, 32'hFFFF_FFFE, 1'b1);
    check_output("tmr_absent", IO_mem_rdata, 32'h0);
    tick();
    check_output("tmr_absent_next", IO_mem_rdata, 32'h0);
`endif

    // Single byte 0x55: exact waveform, latency and busy window.
    starts.delete();
    d55 = 8'h55;
    exp_q.push_back(d55);
    IO_mem_addr  = A_DATA;
    IO_mem_wdata = 32'h55;
    IO_mem_wr    = 1'b1;
    tick();
    wr_cyc = cyc;
    IO_mem_wr = 1'b0;
    wave_err = 0;
    for (int t = 1; t <= 101; t++) begin
      tick();
      if (t < 2) exp_tx = 1'b1;
      else if ((t - 2) / DIV == 0) exp_tx = 1'b0;
      else if ((t - 2) / DIV <= 8) exp_tx = d55[(t - 2) / DIV - 1];
      else exp_tx = 1'b1;
      if (uart_tx !== exp_tx) wave_err++;
      if (t == 50) begin
        read_at(A_STAT, rd);
        check_output("busy_mid_frame", rd, 32'h200);
      end
    end
    check_output("tx_wave_55", wave_err, 32'd0);
    read_at(A_STAT, rd);
    check_output("busy_cleared", rd, 32'h0);
    wait_drain("single_drain", 200);
    check_output("single_start_count", starts.size(), 32'd1);
    if (starts.size() >= 1) check_output("start_latency", starts[0] - wr_cyc, 32'd2);

    // Nine back-to-back writes, overflow and its clear/priority.
    repeat (5) tick();
    starts.delete();
    for (int b = 0; b < 9; b++) begin
      exp_q.push_back(b[7:0]);
      IO_mem_addr  = A_DATA;
      IO_mem_wdata = b;
      IO_mem_wr    = 1'b1;
      tick();
    end
    IO_mem_wr = 1'b0;
    apply_stimulus(A_STAT, 32'h0, 1'b0);
    check_output("fifo_full_status", IO_mem_rdata, 32'h308);
    apply_stimulus(A_DATA, 32'h09, 1'b1);
    read_at(A_STAT, rd);
    check_output("overflow_set", rd, 32'h708);
    apply_stimulus(A_STAT, 32'h0, 1'b1);
    check_output("overflow_clear", IO_mem_rdata, 32'h308);
    apply_stimulus(32'h0040_0018, 32'h77, 1'b1);
    check_output("overflow_wins_clear", IO_mem_rdata, 32'h708);
    apply_stimulus(A_STAT, 32'h0, 1'b1);
    check_output("overflow_clear_again", IO_mem_rdata, 32'h308);
    wait_drain("burst_drain", 1500);
    check_output("burst_start_count", starts.size(), 32'd9);
    for (int k = 1; k < starts.size(); k++) begin
      check_output($sformatf("frame_period_%0d", k), starts[k] - starts[k-1], 32'd101);
    end
    repeat (10) tick();
    read_at(A_STAT, rd);
    check_output("burst_idle_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Memory-mapped IO controller attached to the core's IO port (IO_mem_addr / IO_mem_wdata / IO_mem_wr / IO_mem_rdata).
- Decodes one-hot word addresses and owns three resources:
  - an LED output register;
  - a UART transmitter with a byte FIFO and a serialiser FSM;
  - a status register for software polling.
- The core has no stall input, so every access completes immediately. Flow control is done by software polling the status register.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- BAUD, 115200, UART bit rate. Divisor DIV = CLK_FREQ_HZ/BAUD (integer division), clamped to a minimum of 1.
- FIFO_AW, 3, log2 of TX FIFO depth (depth 8).
- LED_BITS, 6, width of the LED register.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, synchronous active-low reset.
- IO_mem_addr, input, 32, byte address from the core. Word select is IO_mem_addr[15:2], one-hot.
- IO_mem_wdata, input, 32, write data.
- IO_mem_wr, input, 1, write strobe. The core already qualifies it with the IO region bit, so this block does not decode bit 22.
- IO_mem_rdata, output, 32, read data. Combinational from IO_mem_addr.
- LEDS, output, LED_BITS, LED register.
- uart_tx, output, 1, serial line, idle high.

Behaviour:
- Decided: one clock (clk); reset resetn is synchronous, active-low, sampled on posedge clk.
- Word-select bits of IO_mem_addr[15:2]:
  - bit0 = LED;
  - bit1 = UART data;
  - bit2 = UART status;
  - bit3 = timer (optional feature).
- Multiple set bits: every selected write target is updated; read data is the bitwise OR of all selected sources. Unselected or unmapped reads return 0.
- Read timing: IO_mem_rdata is purely combinational from IO_mem_addr and current register state, zero latency. The core samples it at the end of its memory stage.
- Reset values:
  - LEDS = 0, uart_tx = 1.
  - FIFO empty (read/write pointers = 0, count = 0).
  - FSM = IDLE, baud counter = 0, overflow flag = 0.
  - Reset asserted mid-frame: uart_tx goes 1 at that edge; any queued bytes are discarded.
- LED register:
  - Write with bit0 set: LEDS <= IO_mem_wdata[LED_BITS-1:0] at the next edge.
  - Read returns the LED value zero-extended.
- UART data write (bit1 set):
  - If FIFO is not full, push IO_mem_wdata[7:0].
  - If FIFO is full, drop the byte and set the sticky overflow flag. Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even when a pop occurs that cycle.
  - Push and pop in the same cycle: both occur and count is unchanged.
- UART status read (bit2 set) returns:
  - [FIFO_AW:0] = FIFO count, 0..2^FIFO_AW;
  - [8] = full;
  - [9] = busy (FIFO non-empty or FSM not IDLE);
  - [10] = overflow;
  - all other bits 0.
- Status write (bit2 set): clears the overflow flag. A new overflow in the same cycle wins, so the flag stays 1.
- UART data read (bit1 set): returns 0.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx = 1. If FIFO is non-empty, pop the head into the shift register, load the baud counter with DIV-1, and go to START.
  - START: uart_tx = 0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held for DIV cycles. A 3-bit bit index wraps 7 -> STOP.
  - STOP: uart_tx = 1 for DIV cycles, then go to IDLE.
- Baud counter: counts down to 0, then reloads with DIV-1 and advances bit/state.
- Frame timing:
  - One frame = 10*DIV cycles.
  - Back-to-back bytes have exactly one IDLE cycle between frames, giving a period of 10*DIV+1 cycles.
  - The first start bit appears 2 cycles after the pushing write edge (push edge, then IDLE pop edge).
- FIFO: circular buffer; pointers are FIFO_AW bits wide and wrap naturally. Count is FIFO_AW+1 bits wide. full = (count == 2^FIFO_AW); empty = (count == 0).

Optional Feature:
- Macro: IO_TIMER_EN.
- Defined:
  - Adds a 32-bit free-running counter, incremented every clk and reset to 0; it wraps 0xFFFFFFFF -> 0.
  - Read with bit3 set returns the counter value.
  - Write with bit3 set loads IO_mem_wdata on that edge; the increment resumes from the loaded value on the next edge.
- Not defined: no counter logic is synthesised; bit3 reads return 0 and bit3 writes are ignored.

Test Plan:
- Reset with LEDS=0x3F and a frame in progress -> after one reset edge: LEDS=0, uart_tx=1, status read = 0x000.
- Write 0x2A to addr 0x00400004 (bit0) -> LEDS=0x2A next cycle; read at the same address returns 0x0000002A.
- CLK_FREQ_HZ=1000000, BAUD=100000 (DIV=10); write 0x55 to the UART data word (addr 0x00400008) ->
  - uart_tx low 2 cycles after the write edge, for 10 cycles;
  - then bits 1,0,1,0,1,0,1,0 at 10 cycles each;
  - then high for 10 cycles; busy clears after 100 cycles.
- DIV=10; 9 consecutive writes of 0x00..0x08 while idle ->
  - 0x00 is popped immediately; 0x01..0x08 fill the FIFO (status count=8, full=1);
  - a 10th write is dropped and sets overflow (status bit10=1);
  - all 9 bytes are transmitted at a 101-cycle period.
- Overflow set, then status write (addr 0x00400010) -> status bit10 reads 0 next cycle. A status write in the same cycle as an overflowing data write (addr 0x00400018) leaves bit10=1.
- IO_TIMER_EN defined: write 0xFFFFFFFE to the timer word (addr 0x00400020) -> read next cycle = 0xFFFFFFFF, following cycle = 0x00000000. Undefined: the same read returns 0.
